// File: rtl/localbus_pkg.sv
// Shared constants, state encoding and sizing helper for the localbus arbiter.
package localbus_pkg;

  localparam int LB_CMD_READ_BIT = 0;

  localparam int DEF_LBCWIDTH = 8;
  localparam int DEF_LBAWIDTH = 24;
  localparam int DEF_LBDWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } lb_state_e;

  // Width of an index register for n masters, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/localbus_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import localbus_pkg::*;
#(
  parameter int NMASTER = 2,
  parameter int GW      = clog2_min1(NMASTER)
) (
  input  logic [NMASTER-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      grant,
  output logic               found
);

  int unsigned idx;

  // Scan NMASTER slots starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NMASTER; k++) begin
      idx = (32'(ptr) + k) % NMASTER;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/localbus_arbiter.sv
// N-master to 1-slave localbus arbiter: round-robin grant, one outstanding
// transaction, read timeout with error response.
module localbus_arbiter
  import localbus_pkg::*;
#(
  parameter int          NMASTER  = 2,
  parameter int          LBCWIDTH = DEF_LBCWIDTH,
  parameter int          LBAWIDTH = DEF_LBAWIDTH,
  parameter int          LBDWIDTH = DEF_LBDWIDTH,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERRDATA  = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NMASTER-1:0]           m_valid,
  output logic [NMASTER-1:0]           m_ready,
  input  logic [NMASTER*LBCWIDTH-1:0]  m_cmd,
  input  logic [NMASTER*LBAWIDTH-1:0]  m_addr,
  input  logic [NMASTER*LBDWIDTH-1:0]  m_wdata,
  output logic [NMASTER-1:0]           m_rvalid,
  output logic [LBDWIDTH-1:0]          m_rdata,
  output logic                         m_err,
  output logic                         s_valid,
  input  logic                         s_ready,
  output logic [LBCWIDTH-1:0]          s_cmd,
  output logic [LBAWIDTH-1:0]          s_addr,
  output logic [LBDWIDTH-1:0]          s_wdata,
  input  logic                         s_rvalid,
  input  logic [LBDWIDTH-1:0]          s_rdata,
  output logic                         busy
);

  localparam int                GW         = clog2_min1(NMASTER);
  localparam logic [LBDWIDTH-1:0] ERR_RDATA = LBDWIDTH'(ERRDATA);

  lb_state_e             state_q, state_d;
  logic [GW-1:0]         ptr_q, grant_q, pick_g;
  logic                  pick_found;
  logic [LBCWIDTH-1:0]   cmd_q;
  logic [LBAWIDTH-1:0]   addr_q;
  logic [LBDWIDTH-1:0]   wdata_q;
  logic [15:0]           cnt_q;
  logic [LBDWIDTH-1:0]   rsp_data_q;
  logic                  rsp_err_q;
  logic                  timeout_hit;

  rr_pick #(
    .NMASTER (NMASTER),
    .GW      (GW)
  ) u_pick (
    .req   (m_valid),
    .ptr   (ptr_q),
    .grant (pick_g),
    .found (pick_found)
  );

  // cnt_q is (WAIT_RD cycles so far - 1); the response lands TIMEOUT cycles
  // after the accepting cycle, with at least one WAIT_RD cycle.
  assign timeout_hit = ({1'b0, cnt_q} + 17'd2) >= 17'(TIMEOUT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = ISSUE;
      ISSUE:   if (s_ready) state_d = cmd_q[LB_CMD_READ_BIT] ? WAIT_RD : RESP;
      WAIT_RD: if (s_rvalid || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, pointer update, timeout counter and response latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (pick_found) begin
          grant_q <= pick_g;
          ptr_q   <= (pick_g == GW'(NMASTER - 1)) ? '0 : pick_g + GW'(1);
          cmd_q   <= m_cmd[pick_g*LBCWIDTH +: LBCWIDTH];
          addr_q  <= m_addr[pick_g*LBAWIDTH +: LBAWIDTH];
          wdata_q <= m_wdata[pick_g*LBDWIDTH +: LBDWIDTH];
        end
        ISSUE: if (s_ready) begin
          cnt_q <= '0;
          if (!cmd_q[LB_CMD_READ_BIT]) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
          end
        end
        WAIT_RD: begin
          cnt_q <= cnt_q + 16'd1;
          if (s_rvalid) begin
            rsp_data_q <= s_rdata;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_q <= ERR_RDATA;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and latched registers.
  always_comb begin
    m_ready  = '0;
    m_rvalid = '0;
    if (rstn && state_q == IDLE && pick_found) m_ready[pick_g] = 1'b1;
    if (state_q == RESP) m_rvalid[grant_q] = 1'b1;
    s_valid  = (state_q == ISSUE);
    busy     = (state_q != IDLE);
    s_cmd    = cmd_q;
    s_addr   = addr_q;
    s_wdata  = wdata_q;
    m_rdata  = rsp_data_q;
    m_err    = rsp_err_q;
  end

endmodule

// File: doc/localbus_arbiter.md
Name: localbus_arbiter

Overview:
- Parametrised N-master to 1-slave localbus arbiter with round-robin grant and per-transaction read timeout.
- Lets several command sources (UART config path, host/Ethernet path, on-chip sequencer) share the one localbus into the DSP register space.
- Replaces the fixed single-master wiring between config and DSP.
- Generalised in master count, command/address/data width and timeout depth. Adds fair arbitration and error responses.

Parameters:
- NMASTER, 2, number of requesting masters (1..8).
- LBCWIDTH, 8, command width; bit 0 = 1 means read, 0 means write; other bits are passed through.
- LBAWIDTH, 24, address width.
- LBDWIDTH, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for s_rvalid after a read is accepted (1..65535).
- ERRDATA, 32'hDEADBEEF, rdata returned on a timeout (truncated or zero-extended to LBDWIDTH).

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  synchronous active-low reset.
- m_valid  in  NMASTER  per-master request.
- m_ready  out  NMASTER  one-hot; request accepted this cycle.
- m_cmd  in  NMASTER*LBCWIDTH  flattened commands; master i is at [i*LBCWIDTH +: LBCWIDTH].
- m_addr  in  NMASTER*LBAWIDTH  flattened addresses.
- m_wdata  in  NMASTER*LBDWIDTH  flattened write data.
- m_rvalid  out  NMASTER  one-hot completion pulse.
- m_rdata  out  LBDWIDTH  response data, shared; valid where m_rvalid is set.
- m_err  out  1  completion was a timeout; valid with m_rvalid.
- s_valid  out  1  slave request.
- s_ready  in  1  slave accepts the request.
- s_cmd  out  LBCWIDTH  command to slave.
- s_addr  out  LBAWIDTH  address to slave.
- s_wdata  out  LBDWIDTH  write data to slave.
- s_rvalid  in  1  slave read data valid.
- s_rdata  in  LBDWIDTH  slave read data.
- busy  out  1  arbiter is not in IDLE.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, priority pointer=0.
  - All outputs 0: m_ready, m_rvalid, m_rdata, m_err, s_valid, s_cmd, s_addr, s_wdata, busy.
  - Reset mid-transaction abandons the transaction; no response pulse is emitted.
- Arbitration, IDLE state:
  - Search m_valid starting at the pointer and wrapping modulo NMASTER.
  - The first asserted index g wins.
  - In that same cycle: m_ready[g]=1 (combinational, one cycle), master g's cmd/addr/wdata are latched, grant register=g, pointer=(g+1) mod NMASTER, next state=ISSUE.
  - If no master requests, stay in IDLE and keep the pointer.
- ISSUE:
  - s_valid=1 with the latched fields held stable until s_ready.
  - On s_valid and s_ready: if cmd[0]=0 (write), next state=RESP with err=0 and rdata=0. If read, clear the timeout counter and go to WAIT_RD.
  - s_ready is allowed to stay low indefinitely; no timeout applies in ISSUE.
- WAIT_RD:
  - Counter increments each cycle.
  - On s_rvalid: latch s_rdata, err=0, go to RESP.
  - If the counter reaches TIMEOUT with no s_rvalid: rdata=ERRDATA, err=1, go to RESP.
  - If s_rvalid arrives in the same cycle as the counter reaches TIMEOUT, s_rvalid wins and err=0.
  - A late s_rvalid arriving after the timeout is ignored.
- RESP:
  - m_rvalid[grant]=1, m_rdata and m_err valid, for exactly one cycle.
  - Next state=IDLE. A new grant is possible on the cycle after RESP.
- Latency:
  - Write: request accepted at cycle 0 (IDLE); s_valid from cycle 1; completion at cycle s_accept+1.
  - Read with immediate s_ready and s_rvalid on the first WAIT_RD cycle: m_rvalid at cycle 3.
- Requests are non-preemptive; exactly one transaction is outstanding.
- m_valid that drops before m_ready is tolerated; a master is considered only when sampled in IDLE.
- busy=1 in ISSUE, WAIT_RD and RESP.
- NMASTER=1 degenerates to a pass-through with timeout; the pointer is held at 0.

Decomposition:
- Package localbus_pkg:
  - Command-bit constant LB_CMD_READ_BIT=0.
  - State enum {IDLE, ISSUE, WAIT_RD, RESP}.
  - Default widths LBCWIDTH/LBAWIDTH/LBDWIDTH.
  - Function clog2_min1 for grant-register sizing.
- One natural sub-module: rr_pick.
  - Purely combinational: takes m_valid and pointer, returns grant index and found flag.
  - Separately unit-testable.

Test Plan:
- Single write: NMASTER=2; m0 write addr 24'h000100, data 32'h12345678; s_ready tied 1. Expect s_valid at cycle 1 with the same addr/data, m_rvalid=2'b01 at cycle 2, m_err=0.
- Read: m1 read addr 24'h000200; slave returns 32'hCAFEF00D two cycles after accept. Expect m_rvalid=2'b10, m_rdata=32'hCAFEF00D, m_err=0.
- Round-robin: both masters request continuously for 4 writes. Expect grant order 0,1,0,1 and no starvation. With NMASTER=4 and masters 1 and 3 active, expect 1,3,1,3.
- Timeout: TIMEOUT=10, read, s_rvalid never asserts. Expect m_rvalid exactly 10 cycles after accept, m_rdata=32'hDEADBEEF, m_err=1. A subsequent s_rvalid produces no response.
- Boundary: s_rvalid on the same cycle the counter reaches TIMEOUT, so the response has err=0 with slave data. s_ready held low 1000 cycles: s_valid stays asserted with stable fields and no error.
- Reset mid-read: deassert rstn during WAIT_RD. All outputs 0 next cycle, no m_rvalid, pointer=0; the next request from m1 is granted normally.
